// File: rtl/api_chip_resp.sv
// api_chip_resp: chip-side responder for the load/sck/mosi/miso link.
// Deserialises work frames and returns header + queued nonces on miso.
// The optional last-word XOR integrity check is enabled by defining API_RESP_XOR_EN.
module api_chip_resp #(
  parameter int WORK_LEN    = 23,
  parameter int NONCE_DEPTH = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        sck,
  input  logic        mosi,
  output logic        miso,
  output logic        work_valid,
  output logic [31:0] work_data,
  output logic        work_last,
  output logic        frame_ok,
  output logic        frame_err,
  input  logic        nonce_push,
  input  logic [31:0] nonce_din,
  output logic        nonce_full,
  output logic        nonce_drop
);
  localparam int AW  = $clog2(NONCE_DEPTH);
  localparam int CW  = $clog2(NONCE_DEPTH + 1);
  localparam int WCW = $clog2(WORK_LEN + 1);
  localparam logic [7:0]     N_MAX  = 8'(WORK_LEN - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(WORK_LEN - 1);
  localparam logic [WCW-1:0] W_ALL  = WCW'(WORK_LEN);
  localparam logic [CW-1:0]  C_FULL = CW'(NONCE_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;

  // Synchronisers are not reset, so a load that is already high when reset
  // releases never looks like a rising edge; the frame is ignored until load
  // goes low and rises again.
  logic [SYNC_STAGES-1:0] load_sync_q, sck_sync_q, mosi_sync_q;
  logic load_prev_q, sck_prev_q;
  always_ff @(posedge clk) begin
    load_sync_q <= {load_sync_q[SYNC_STAGES-2:0], load};
    sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    load_prev_q <= load_sync_q[SYNC_STAGES-1];
    sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
  end

  logic load_s, sck_s, mosi_s;
  logic load_rise, load_fall, sck_rise, sck_fall;
  assign load_s    = load_sync_q[SYNC_STAGES-1];
  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign load_rise = load_s & ~load_prev_q;
  assign load_fall = ~load_s & load_prev_q;
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign sck_fall  = ~sck_s & sck_prev_q;

  logic [31:0]    tx_sr_q, next_word_q;
  logic [30:0]    rx_sr_q;
  logic [31:0]    rx_next;
  logic [4:0]     bit_cnt_q;
  logic [WCW-1:0] word_cnt_q;
  logic [7:0]     n_q, n_snap, cnt8;
  logic           overrun_q, reload_q;
  logic           work_valid_q, work_last_q, frame_ok_q, frame_err_q;
  logic [31:0]    work_data_q;
  logic           start, word_done, frame_end, frame_good, xor_ok, pop;

  logic [31:0]    mem_q [NONCE_DEPTH];
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q, drop_q, push_ok;

  assign rx_next = {rx_sr_q, mosi_s};
  assign cnt8    = 8'(count_q);
  assign n_snap  = (cnt8 > N_MAX) ? N_MAX : cnt8;
  assign pop     = word_done && ((8'(word_cnt_q) + 8'd1) <= n_q);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_rise) state_d = SHIFT;
      SHIFT:   if (load_fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    start      = 1'b0;
    word_done  = 1'b0;
    frame_end  = 1'b0;
    frame_good = 1'b0;
    case (state_q)
      IDLE:  start = load_rise;
      SHIFT: begin
        word_done  = sck_rise && (bit_cnt_q == 5'd31);
        frame_end  = load_fall;
        frame_good = (word_cnt_q == W_ALL) && (bit_cnt_q == 5'd0) && !overrun_q && xor_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr_q      <= '0;
      rx_sr_q      <= '0;
      next_word_q  <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      n_q          <= '0;
      overrun_q    <= 1'b0;
      reload_q     <= 1'b0;
      work_valid_q <= 1'b0;
      work_data_q  <= '0;
      work_last_q  <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      work_valid_q <= 1'b0;
      work_last_q  <= 1'b0;
      frame_ok_q   <= frame_end && frame_good;
      frame_err_q  <= frame_end && !frame_good;
      if (start) begin
        tx_sr_q    <= {8'h5A, n_snap, 16'h0000};
        n_q        <= n_snap;
        bit_cnt_q  <= '0;
        word_cnt_q <= '0;
        overrun_q  <= 1'b0;
        reload_q   <= 1'b0;
      end
      if (state_q == SHIFT) begin
        if (sck_rise) begin
          rx_sr_q   <= rx_next[30:0];
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
        if (word_done) begin
          if (word_cnt_q < W_ALL) begin
            work_valid_q <= 1'b1;
            work_data_q  <= rx_next;
            work_last_q  <= (word_cnt_q == W_LAST);
            word_cnt_q   <= word_cnt_q + WCW'(1);
          end else begin
            overrun_q <= 1'b1;
          end
          next_word_q <= pop ? mem_q[rd_ptr_q] : 32'hFFFF_FFFF;
          reload_q    <= 1'b1;
        end
        // The reply word is swapped in on the fall after a boundary so miso
        // is stable well before the controller's next sampling rise.
        if (sck_fall) begin
          if (reload_q) begin
            tx_sr_q  <= next_word_q;
            reload_q <= 1'b0;
          end else begin
            tx_sr_q <= {tx_sr_q[30:0], 1'b0};
          end
        end
        if (frame_end) tx_sr_q <= '0;
      end
    end
  end

`ifdef API_RESP_XOR_EN
  logic [31:0] xor_acc_q;
  logic        xor_bad_q;
  always_ff @(posedge clk) begin
    if (rst || start) begin
      xor_acc_q <= '0;
      xor_bad_q <= 1'b0;
    end else if (word_done && (word_cnt_q < W_ALL)) begin
      if (word_cnt_q == W_LAST) xor_bad_q <= (rx_next != xor_acc_q);
      else                      xor_acc_q <= xor_acc_q ^ rx_next;
    end
  end
  assign xor_ok = !xor_bad_q;
`else
  assign xor_ok = 1'b1;
`endif

  // A push into a full FIFO is only accepted when a pop frees a slot that cycle.
  assign push_ok = nonce_push && (!full_q || pop);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= nonce_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full_q  <= (count_d == C_FULL);
      drop_q  <= nonce_push && !push_ok;
    end
  end

  assign miso       = tx_sr_q[31];
  assign work_valid = work_valid_q;
  assign work_data  = work_data_q;
  assign work_last  = work_last_q;
  assign frame_ok   = frame_ok_q;
  assign frame_err  = frame_err_q;
  assign nonce_full = full_q;
  assign nonce_drop = drop_q;
endmodule
